// File: rtl/locked_register_bank.sv
// locked_register_bank: write-protected register bank with sticky locks and a trusted debug window; VIOLATION_CNT_EN adds a rejected-write counter
module locked_register_bank #(
  parameter int                DATA_W    = 16,
  parameter int                NUM_REGS  = 8,
  parameter int                ADDR_W    = $clog2(NUM_REGS),
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 8
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic                lock_req,
  input  logic [ADDR_W-1:0]   lock_addr,
  input  logic                lock_all,
  input  logic                trusted,
  input  logic                debug_mode,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   Data_out,
  output logic [NUM_REGS-1:0] lock_status,
  output logic                dbg_open,
  output logic                write_ack,
  output logic                write_err,
  output logic [CNT_W-1:0]    viol_count
);
  typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);
  state_t state_q, state_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] lock_q, lock_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic ack_q, ack_d, err_q, err_d;
  logic addr_ok, rd_ok, lock_ok, wr_ok;
  assign addr_ok = {1'b0, addr} < NREGS;
  assign rd_ok = {1'b0, rd_addr} < NREGS;
  assign lock_ok = {1'b0, lock_addr} < NREGS;
  assign wr_ok = write & addr_ok & (~lock_q[addr] | (state_q == OPEN));
  // debug window FSM: once trust is lost inside the window it stays shut until debug_mode drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (debug_mode & trusted) ? OPEN : IDLE;
      OPEN:    state_d = ~debug_mode ? IDLE : (~trusted ? LOCKOUT : OPEN);
      LOCKOUT: state_d = ~debug_mode ? IDLE : LOCKOUT;
      default: state_d = IDLE;
    endcase
  end
  // register file update, sticky locks, registered read and one-cycle write status
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[addr] = Data_in;
    lock_d = lock_q | {NUM_REGS{lock_all}} | ((lock_req & lock_ok) ? NUM_REGS'(1) << lock_addr : '0);
    dout_d = rd_ok ? regs_q[rd_addr] : '0;
    ack_d = wr_ok;
    err_d = write & ~wr_ok;
  end
  // state registers
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      regs_q <= '{default: RESET_VAL};
      lock_q <= '0;
      dout_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q <= regs_d;
      lock_q <= lock_d;
      dout_q <= dout_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end
`ifdef VIOLATION_CNT_EN
  logic [CNT_W-1:0] viol_q, viol_d;
  // saturating count of rejected writes
  always_comb viol_d = (err_d && viol_q != '1) ? viol_q + 1'b1 : viol_q;
  // violation counter register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) viol_q <= '0;
    else viol_q <= viol_d;
  end
  assign viol_count = viol_q;
`else
  assign viol_count = '0;
`endif
  assign Data_out = dout_q;
  assign lock_status = lock_q;
  assign dbg_open = state_q == OPEN;
  assign write_ack = ack_q;
  assign write_err = err_q;
endmodule

// File: tb/tb_locked_register_bank.sv
// tb_locked_register_bank: randomized scoreboard bench against a behavioural model of the locked register bank
module tb_locked_register_bank;
  localparam int DW = 16, NR = 8, AW = 3, CW = 8;
  logic Clk = 1'b0, reset = 1'b1;
  logic write = 0, lock_req = 0, lock_all = 0, trusted = 0, debug_mode = 0;
  logic [AW-1:0] addr = '0, lock_addr = '0, rd_addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] Data_out;
  logic [NR-1:0] lock_status;
  logic dbg_open, write_ack, write_err;
  logic [CW-1:0] viol_count;

  always #5 Clk = ~Clk;

  locked_register_bank dut (
    .Clk(Clk), .reset(reset), .write(write), .addr(addr), .Data_in(din),
    .lock_req(lock_req), .lock_addr(lock_addr), .lock_all(lock_all),
    .trusted(trusted), .debug_mode(debug_mode), .rd_addr(rd_addr),
    .Data_out(Data_out), .lock_status(lock_status), .dbg_open(dbg_open),
    .write_ack(write_ack), .write_err(write_err), .viol_count(viol_count)
  );

  typedef struct {
    logic [DW-1:0] dout;
    logic ack, err, open;
    logic [NR-1:0] lock;
    logic [CW-1:0] viol;
  } exp_t;
  exp_t q[$];
  exp_t me;

  logic [DW-1:0] mem [NR];
  logic [NR-1:0] mlock;
  bit mopen, mburnt;
  int mviol;
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    foreach (mem[i]) mem[i] = '0;
    mlock = '0;
    mopen = 0;
    mburnt = 0;
    mviol = 0;
  endtask

  // Predict the outputs after the coming edge from the current inputs, then let the edge happen.
  task automatic step();
    exp_t e;
    bit acc;
    acc = write && (int'(addr) < NR) && (!mlock[addr] || mopen);
    e.ack = acc;
    e.err = write && !acc;
    e.dout = (int'(rd_addr) < NR) ? mem[rd_addr] : '0;
    if (acc) mem[addr] = din;
`ifdef VIOLATION_CNT_EN
    if (e.err && mviol < (1 << CW) - 1) mviol++;
`endif
    if (lock_all) mlock = '1;
    if (lock_req && int'(lock_addr) < NR) mlock[lock_addr] = 1'b1;
    if (mopen) begin
      if (!debug_mode) mopen = 0;
      else if (!trusted) begin mopen = 0; mburnt = 1; end
    end else if (mburnt) begin
      if (!debug_mode) mburnt = 0;
    end else if (debug_mode && trusted) mopen = 1;
    e.lock = mlock;
    e.open = mopen;
    e.viol = CW'(mviol);
    @(posedge Clk);
    q.push_back(e);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, 32'(Data_out), 0);
    chk({tag, "_lock"}, 32'(lock_status), 0);
    chk({tag, "_open"}, 32'(dbg_open), 0);
    chk({tag, "_ack"}, 32'(write_ack), 0);
    chk({tag, "_err"}, 32'(write_err), 0);
    chk({tag, "_viol"}, 32'(viol_count), 0);
  endtask

  // Assert reset asynchronously half-way through a cycle, hold across an edge, release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge Clk);
    #1 reset = 1;
    #1 check_reset_outputs({tag, "_async"});
    model_reset();
    @(posedge Clk);
    #1 check_reset_outputs({tag, "_held"});
    {write, lock_req, lock_all, debug_mode, trusted} = '0;
    @(negedge Clk);
    reset = 0;
  endtask

  always @(negedge Clk) begin
    if (!reset && q.size() > 0) begin
      me = q.pop_front();
      chk("data_out", 32'(Data_out), 32'(me.dout));
      chk("write_ack", 32'(write_ack), 32'(me.ack));
      chk("write_err", 32'(write_err), 32'(me.err));
      chk("lock_status", 32'(lock_status), 32'(me.lock));
      chk("dbg_open", 32'(dbg_open), 32'(me.open));
      chk("viol_count", 32'(viol_count), 32'(me.viol));
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = 1; addr = a; din = d;
  endtask

  initial begin
    model_reset();
    #12 check_reset_outputs("por");
    @(negedge Clk);
    reset = 0;
    // 1: plain write then registered read
    wr(3, 16'hA5A5); step();
    write = 0; rd_addr = 3; step(); step();
    // 2: lock then rejected write
    lock_req = 1; lock_addr = 3; step();
    lock_req = 0; wr(3, 16'h1234); step();
    write = 0; step(); step();
    // 3: same-cycle write and lock judged on old lock bit
    wr(5, 16'hBEEF); lock_req = 1; lock_addr = 5; step();
    lock_req = 0; wr(5, 16'h1111); step();
    write = 0; rd_addr = 5; step(); step();
    // 4: debug window overrides lock without clearing it
    debug_mode = 1; trusted = 1; step();
    wr(3, 16'h0F0F); step();
    write = 0; rd_addr = 3; step(); step();
    // 5: trust lost inside window -> lockout, no reopen until debug_mode drops
    trusted = 0; step();
    trusted = 1; wr(3, 16'h7777); step();
    write = 0; step();
    debug_mode = 0; step();
    debug_mode = 1; step();
    debug_mode = 0; step();
    // first-rise cycle still sees a closed window
    debug_mode = 1; trusted = 1; wr(3, 16'h5555); step();
    write = 0; step();
    debug_mode = 0; trusted = 0; step();
    // 6: reset mid-burst with lock_all
    wr(2, 16'hCAFE); step();
    wr(6, 16'hD00D); lock_all = 1;
    do_reset("mid");
    for (int i = 0; i < NR; i++) begin rd_addr = AW'(i); step(); end
    step();
    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset("rnd");
      write = ($urandom_range(0, 1) == 1);
      addr = AW'($urandom);
      din = DW'($urandom);
      rd_addr = AW'($urandom);
      lock_req = ($urandom_range(0, 19) == 0);
      lock_addr = AW'($urandom);
      lock_all = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) debug_mode = ~debug_mode;
      if ($urandom_range(0, 5) == 0) trusted = ~trusted;
      step();
    end
`ifdef VIOLATION_CNT_EN
    do_reset("sat");
    lock_all = 1; step();
    lock_all = 0;
    for (int n = 0; n < 270; n++) begin wr(AW'(n), DW'(n)); step(); end
    write = 0; step();
`endif
    write = 0; lock_req = 0; lock_all = 0;
    repeat (3) @(negedge Clk);
    #1 chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
